// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and constants for the clock/alarm time-edit logic.
//   state_e       - time-set FSM states
//   bcd_t         - one BCD digit
//   MAX_HOUR/MIN  - last legal value of the hours/minutes field
//   BTN_*         - index of each button in the conditioned button vector
//   bcd_field_inc - increment of a two-digit BCD field with wrap/sanitize
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] MAX_HOUR = 8'd23;
  localparam logic [7:0] MAX_MIN  = 8'd59;

  localparam int NUM_BTN = 3;
  localparam int BTN_SET = 0;
  localparam int BTN_HR  = 1;
  localparam int BTN_MIN = 2;

  // Increment a {tens,units} BCD field. The last legal value wraps to 00,
  // and a field that is not a legal value (bad digit or above max_val) is
  // cleaned up to 00 rather than propagated.
  function automatic logic [7:0] bcd_field_inc(input logic [7:0] field,
                                               input logic [7:0] max_val);
    bcd_t       tens;
    bcd_t       units;
    logic [7:0] bin;
    tens  = field[7:4];
    units = field[3:0];
    bin   = ({4'd0, tens} * 8'd10) + {4'd0, units};
    if ((tens > 4'd9) || (units > 4'd9) || (bin >= max_val))
      return 8'h00;
    else if (units == 4'd9)
      return {tens + 4'd1, 4'd0};
    else
      return {tens, units + 4'd1};
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop synchronizer, debouncer and rising-edge pulse
// for one raw mechanical button.
//   clk, reset_n    - clock, async active-low reset
//   btn_raw         - raw asynchronous button level
//   press           - one-cycle pulse per accepted 0->1 debounced transition
// After reset the conditioner is unarmed: the button must be seen stably
// released for DEBOUNCE_CYCLES before any press is accepted, so a button
// held through reset never produces a spurious press.
module button_conditioner
  #(parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000)
  (input  logic clk,
   input  logic reset_n,
   input  logic btn_raw,
   output logic press);

  localparam logic [15:0] LAST = DEBOUNCE_CYCLES - 16'd1;

  logic        sync1_q, sync2_q;
  logic [15:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        armed_q, armed_d;
  logic        press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    armed_d = armed_q;
    press_d = 1'b0;
    if (!armed_q) begin
      // Wait for a stable release; the level stays 0 meanwhile.
      if (sync2_q)             cnt_d = '0;
      else if (cnt_q == LAST) begin
        armed_d = 1'b1;
        cnt_d   = '0;
      end else                 cnt_d = cnt_q + 16'd1;
    end else if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: three-button HH:MM time-setting FSM.
//   clk, reset_n   - clock, async active-low reset
//   set_mode_btn   - raw button: enter set mode / next field / commit
//   hour_btn       - raw button: increment hours (in SET_HR)
//   min_btn        - raw button: increment minutes (in SET_MIN)
//   display_value  - current BCD time HH:MM, captured on entering set mode
//   new_time       - proposed BCD time (registered)
//   set_time       - one-cycle commit strobe (registered)
//   editing        - high in SET_HR / SET_MIN (registered)
//   edit_field     - 0 hours, 1 minutes (registered)
module time_set_controller
  import alarm_pkg::*;
  #(parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd500000000)
  (input  logic        clk,
   input  logic        reset_n,
   input  logic        set_mode_btn,
   input  logic        hour_btn,
   input  logic        min_btn,
   input  logic [15:0] display_value,
   output logic [15:0] new_time,
   output logic        set_time,
   output logic        editing,
   output logic        edit_field);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press_p;

  assign btn_raw[BTN_SET] = set_mode_btn;
  assign btn_raw[BTN_HR]  = hour_btn;
  assign btn_raw[BTN_MIN] = min_btn;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_raw (btn_raw[g]),
      .press   (press_p[g])
    );
  end

  state_e      state_q, state_d;
  logic [15:0] new_time_q, new_time_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        set_time_q, set_time_d;
  logic        editing_q, editing_d;
  logic        edit_field_q, edit_field_d;

  logic set_p, hr_p, min_p, any_p, timeout;

  assign set_p   = press_p[BTN_SET];
  assign hr_p    = press_p[BTN_HR];
  assign min_p   = press_p[BTN_MIN];
  assign any_p   = |press_p;
  assign timeout = (to_cnt_q >= TIMEOUT_CYCLES);

  always_comb begin
    state_d    = state_q;
    new_time_d = new_time_q;
    to_cnt_d   = to_cnt_q;
    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (set_p) begin
          new_time_d = display_value;
          state_d    = SET_HR;
        end
      end
      // set_mode wins over an increment in the same cycle; a press in the
      // same cycle as the timeout keeps the edit alive.
      SET_HR: begin
        if (set_p)        state_d = SET_MIN;
        else if (hr_p)    new_time_d[15:8] = bcd_field_inc(new_time_q[15:8], MAX_HOUR);
        else if (timeout) state_d = IDLE;
      end
      SET_MIN: begin
        if (set_p)        state_d = COMMIT;
        else if (min_p)   new_time_d[7:0] = bcd_field_inc(new_time_q[7:0], MAX_MIN);
        else if (timeout) state_d = IDLE;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == SET_HR || state_q == SET_MIN) begin
      if (any_p)         to_cnt_d = '0;
      else if (!timeout) to_cnt_d = to_cnt_q + 32'd1;
    end

    // Outputs are registered copies of the next-state decode so they line
    // up with the state they describe.
    set_time_d   = (state_d == COMMIT);
    editing_d    = (state_d == SET_HR) || (state_d == SET_MIN);
    edit_field_d = (state_d == SET_MIN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      new_time_q   <= 16'h0000;
      to_cnt_q     <= '0;
      set_time_q   <= 1'b0;
      editing_q    <= 1'b0;
      edit_field_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      new_time_q   <= new_time_d;
      to_cnt_q     <= to_cnt_d;
      set_time_q   <= set_time_d;
      editing_q    <= editing_d;
      edit_field_q <= edit_field_d;
    end
  end

  assign new_time   = new_time_q;
  assign set_time   = set_time_q;
  assign editing    = editing_q;
  assign edit_field = edit_field_q;

endmodule

// File: tb/tb_time_set_controller.sv
module tb_time_set_controller;

  localparam int DEB  = 8;
  localparam int HOLD = DEB + 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        set_mode_btn = 1'b0;
  logic        hour_btn = 1'b0;
  logic        min_btn = 1'b0;
  logic [15:0] display_value = 16'h0000;
  logic [15:0] new_time;
  logic        set_time;
  logic        editing;
  logic        edit_field;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;   // running count of set_time pulses
  int base;

  always #5 clk = ~clk;

  always @(posedge clk) if (set_time === 1'b1) pulses <= pulses + 1;

  time_set_controller #(.DEBOUNCE_CYCLES(16'd8), .TIMEOUT_CYCLES(32'd200)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .set_mode_btn  (set_mode_btn),
    .hour_btn      (hour_btn),
    .min_btn       (min_btn),
    .display_value (display_value),
    .new_time      (new_time),
    .set_time      (set_time),
    .editing       (editing),
    .edit_field    (edit_field)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press: hold well past the debounce window, then release likewise.
  task automatic press(input logic s, input logic h, input logic m);
    set_mode_btn = s; hour_btn = h; min_btn = m;
    cyc(HOLD);
    set_mode_btn = 1'b0; hour_btn = 1'b0; min_btn = 1'b0;
    cyc(HOLD);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cyc(3);
    n_cmp++; if (new_time !== 16'h0000) begin n_err++; $display("FAIL rst_new_time: got %h want 0000", new_time); end
    n_cmp++; if (set_time !== 1'b0) begin n_err++; $display("FAIL rst_set_time: got %b want 0", set_time); end
    n_cmp++; if (editing !== 1'b0) begin n_err++; $display("FAIL rst_editing: got %b want 0", editing); end
    n_cmp++; if (edit_field !== 1'b0) begin n_err++; $display("FAIL rst_edit_field: got %b want 0", edit_field); end
    reset_n = 1'b1;
    cyc(2 * DEB + 4);
  endtask

  task automatic test_idle_ignore;
    display_value = 16'h0930;
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    n_cmp++; if (editing !== 1'b0) begin n_err++; $display("FAIL idle_editing: got %b want 0", editing); end
    n_cmp++; if (new_time !== 16'h0000) begin n_err++; $display("FAIL idle_new_time: got %h want 0000", new_time); end
  endtask

  task automatic test_capture_commit;
    display_value = 16'h1259;
    press(1'b1, 1'b0, 1'b0);
    n_cmp++; if (editing !== 1'b1) begin n_err++; $display("FAIL cap_editing: got %b want 1", editing); end
    n_cmp++; if (edit_field !== 1'b0) begin n_err++; $display("FAIL cap_field_hr: got %b want 0", edit_field); end
    n_cmp++; if (new_time !== 16'h1259) begin n_err++; $display("FAIL cap_new_time: got %h want 1259", new_time); end
    display_value = 16'h0101;  // live display moving must not disturb the edit
    press(1'b1, 1'b0, 1'b0);
    n_cmp++; if (edit_field !== 1'b1) begin n_err++; $display("FAIL cap_field_min: got %b want 1", edit_field); end
    base = pulses;
    press(1'b1, 1'b0, 1'b0);
    n_cmp++; if (pulses - base !== 1) begin n_err++; $display("FAIL cap_pulses: got %0d want 1", pulses - base); end
    n_cmp++; if (editing !== 1'b0) begin n_err++; $display("FAIL cap_idle: got %b want 0", editing); end
    n_cmp++; if (new_time !== 16'h1259) begin n_err++; $display("FAIL cap_commit_val: got %h want 1259", new_time); end
  endtask

  task automatic test_wrap;
    display_value = 16'h2359;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    n_cmp++; if (new_time !== 16'h0059) begin n_err++; $display("FAIL wrap_hr: got %h want 0059", new_time); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    n_cmp++; if (new_time !== 16'h0000) begin n_err++; $display("FAIL wrap_min: got %h want 0000", new_time); end
    base = pulses;
    press(1'b1, 1'b0, 1'b0);
    n_cmp++; if (pulses - base !== 1) begin n_err++; $display("FAIL wrap_pulses: got %0d want 1", pulses - base); end
  endtask

  task automatic test_increment;
    display_value = 16'h0919;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);  // minute button ignored in SET_HR
    n_cmp++; if (new_time !== 16'h0919) begin n_err++; $display("FAIL inc_min_in_hr: got %h want 0919", new_time); end
    press(1'b0, 1'b1, 1'b0);
    n_cmp++; if (new_time !== 16'h1019) begin n_err++; $display("FAIL inc_hr_carry: got %h want 1019", new_time); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);  // hour button ignored in SET_MIN
    n_cmp++; if (new_time !== 16'h1019) begin n_err++; $display("FAIL inc_hr_in_min: got %h want 1019", new_time); end
    press(1'b0, 1'b0, 1'b1);
    n_cmp++; if (new_time !== 16'h1020) begin n_err++; $display("FAIL inc_min_carry: got %h want 1020", new_time); end
    press(1'b1, 1'b0, 1'b0);
    // invalid captured value: bad hour digit, minutes above 59
    display_value = 16'h2A75;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    n_cmp++; if (new_time !== 16'h0075) begin n_err++; $display("FAIL inv_hr: got %h want 0075", new_time); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    n_cmp++; if (new_time !== 16'h0000) begin n_err++; $display("FAIL inv_min: got %h want 0000", new_time); end
    press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_debounce;
    display_value = 16'h0800;
    press(1'b1, 1'b0, 1'b0);
    hour_btn = 1'b1; cyc(3); hour_btn = 1'b0; cyc(20);
    hour_btn = 1'b1; cyc(5); hour_btn = 1'b0; cyc(2);
    hour_btn = 1'b1; cyc(4); hour_btn = 1'b0; cyc(3);
    hour_btn = 1'b1; cyc(2); hour_btn = 1'b0; cyc(20);
    n_cmp++; if (new_time !== 16'h0800) begin n_err++; $display("FAIL deb_glitch: got %h want 0800", new_time); end
    press(1'b0, 1'b1, 1'b0);
    cyc(20);
    n_cmp++; if (new_time !== 16'h0900) begin n_err++; $display("FAIL deb_clean: got %h want 0900", new_time); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous;
    display_value = 16'h1000;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    n_cmp++; if (edit_field !== 1'b1 || editing !== 1'b1) begin n_err++; $display("FAIL sim_state: got ed=%b fld=%b want ed=1 fld=1", editing, edit_field); end
    n_cmp++; if (new_time !== 16'h1000) begin n_err++; $display("FAIL sim_hours: got %h want 1000", new_time); end
    press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    display_value = 16'h0415;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    base = pulses;
    cyc(150);   // still inside the inactivity window
    n_cmp++; if (editing !== 1'b1 || edit_field !== 1'b1) begin n_err++; $display("FAIL to_early: got ed=%b fld=%b want ed=1 fld=1", editing, edit_field); end
    cyc(50);    // now past it
    n_cmp++; if (editing !== 1'b0) begin n_err++; $display("FAIL to_editing: got %b want 0", editing); end
    n_cmp++; if (pulses - base !== 0) begin n_err++; $display("FAIL to_pulses: got %0d want 0", pulses - base); end
    n_cmp++; if (new_time !== 16'h0415) begin n_err++; $display("FAIL to_new_time: got %h want 0415", new_time); end
  endtask

  task automatic test_reset_mid_edit;
    display_value = 16'h1111;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    base = pulses;
    set_mode_btn = 1'b1;   // held through reset release
    reset_n = 1'b0;
    cyc(3);
    n_cmp++; if (new_time !== 16'h0000) begin n_err++; $display("FAIL rmid_new_time: got %h want 0000", new_time); end
    n_cmp++; if (editing !== 1'b0 || set_time !== 1'b0) begin n_err++; $display("FAIL rmid_outs: got ed=%b st=%b want 0 0", editing, set_time); end
    reset_n = 1'b1;
    cyc(40);
    n_cmp++; if (editing !== 1'b0) begin n_err++; $display("FAIL rmid_held_btn: got %b want 0", editing); end
    n_cmp++; if (pulses - base !== 0) begin n_err++; $display("FAIL rmid_pulses: got %0d want 0", pulses - base); end
    set_mode_btn = 1'b0;
    cyc(2 * DEB + 4);
    press(1'b1, 1'b0, 1'b0);
    n_cmp++; if (editing !== 1'b1 || new_time !== 16'h1111) begin n_err++; $display("FAIL rmid_repress: got ed=%b nt=%h want 1 1111", editing, new_time); end
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(2 * DEB + 4);
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_capture_commit();
    test_wrap();
    test_increment();
    test_debounce();
    test_simultaneous();
    test_timeout();
    test_reset_mid_edit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, meaning the number of clk cycles a synchronized button must hold one level before that level is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32'd500000000, meaning the number of clk cycles of edit inactivity before the edit is abandoned.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port set_mode_btn  input  1  raw asynchronous button: enter set mode / advance field / commit.
REQ-006 SHALL have port hour_btn  input  1  raw asynchronous button: increment hours.
REQ-007 SHALL have port min_btn  input  1  raw asynchronous button: increment minutes.
REQ-008 SHALL have port display_value  input  16  current time from the counting logic as BCD HH:MM, with [15:12] hour tens, [11:8] hour units, [7:4] minute tens and [3:0] minute units.
REQ-009 SHALL have port new_time  output  16  proposed time in the same BCD layout as display_value.
REQ-010 SHALL have port set_time  output  1  one-cycle pulse that commits new_time to the counting logic.
REQ-011 SHALL have port editing  output  1  high while the FSM is in SET_HR or SET_MIN.
REQ-012 SHALL have port edit_field  output  1  0 = hours field selected, 1 = minutes field selected; valid only while editing is high.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer and then a debouncer, and SHALL produce a one-cycle press pulse on each accepted 0->1 transition.
REQ-014 SHALL release no further press pulse until the debounced level has returned to 0.
REQ-015 SHALL implement the FSM states IDLE, SET_HR, SET_MIN and COMMIT.
REQ-016 SHALL, in IDLE on a set_mode press, load new_time from display_value and move to SET_HR on the same edge.
REQ-017 SHALL ignore hour and minute presses while in IDLE.
REQ-018 SHALL, in SET_HR on an hour press, increment the BCD hours field: units 9 -> 0 with tens+1, and 23 -> 00.
REQ-019 SHALL, in SET_MIN on a minute press, increment the BCD minutes field: units 9 -> 0 with tens+1, and 59 -> 00.
REQ-020 SHALL ignore the minute button in SET_HR and the hour button in SET_MIN.
REQ-021 SHALL, on an increment of a field that holds an invalid captured value (any digit > 9, hours > 23, or minutes > 59), set that field to 00.
REQ-022 SHALL move SET_HR -> SET_MIN and SET_MIN -> COMMIT on a set_mode press.
REQ-023 SHALL, in COMMIT, assert set_time for exactly one cycle and return to IDLE on the next edge.
REQ-024 SHALL give a set_mode press priority when it arrives in the same cycle as an increment press, and SHALL discard that increment.
REQ-025 SHALL keep an inactivity counter that clears on entry to SET_HR and on every accepted press.
REQ-026 SHALL, when the inactivity counter reaches TIMEOUT_CYCLES in SET_HR or SET_MIN, return to IDLE without a set_time pulse.
REQ-027 SHALL hold new_time stable in IDLE and SHALL change it only on a capture (REQ-016) or an increment (REQ-018, REQ-019).
REQ-028 SHALL register all outputs.

Reset
REQ-029 SHALL, while reset_n is low, force: state IDLE, new_time 16'h0000, set_time 0, editing 0, edit_field 0, all debouncer and timeout counters 0, and all debounced levels 0.
REQ-030 SHALL, on reset assertion during SET_HR, SET_MIN or COMMIT, abort the edit with no set_time pulse generated.
REQ-031 SHALL require a button that is held through reset deassertion to be released and pressed again before it produces a press pulse.

Structure
REQ-032 SHALL take the FSM state enum, the BCD digit type, MAX_HOUR = 23 and MAX_MIN = 59 from the shared package alarm_pkg.
REQ-033 SHALL use one sub-module, button_conditioner (synchronizer, debouncer and rising-edge pulse), instantiated three times.

Verification
REQ-034 SHALL verify capture and commit: display_value 16'h1259, then set_mode, set_mode, set_mode -> new_time 16'h1259, exactly one set_time pulse, FSM back in IDLE.
REQ-035 SHALL verify wrap-around: capture 16'h2359, hour press in SET_HR, set_mode, minute press -> new_time 16'h0000, and a commit pulses set_time once.
REQ-036 SHALL verify debounce: a 3-cycle glitch plus bouncing shorter than DEBOUNCE_CYCLES on hour_btn in SET_HR -> no increment; a single clean press -> hours +1 exactly once.
REQ-037 SHALL verify timeout: enter SET_MIN and then apply no presses for TIMEOUT_CYCLES -> editing drops to 0, set_time never asserted, new_time unchanged.
REQ-038 SHALL verify simultaneous presses: set_mode and hour press accepted in the same cycle in SET_HR -> state SET_MIN, hours unchanged.
REQ-039 SHALL verify reset mid-edit: reset_n asserted in SET_MIN -> new_time 16'h0000, editing 0, set_time 0, and no pulse after release.
